cla_adder: RTL and testbench

//  Parameterised WIDTH-bit two-level carry-lookahead adder: s/cout = a + b + cin.

---
 rtl/cla_adder_pkg.sv | 28 ++
 rtl/cla_adder_if.sv | 16 +
 rtl/cla_group.sv | 37 +++
 rtl/cla_adder.sv | 67 ++++++
 tb/tb_cla_adder.sv | 135 +++++++++++++
 5 files changed

// File: rtl/cla_adder_pkg.sv
// Shared constants and the flat sum-of-products carry helper for the CLA adder.
// Pure compile-time content; no logic of its own.
package cla_adder_pkg;

    localparam int unsigned DEF_WIDTH = 32;
    localparam int unsigned DEF_SIZE  = 4;
    localparam int unsigned MAX_SIZE  = 8;

    // Carry into bit n of a group: g[n-1] | p[n-1]&g[n-2] | ... | p[n-1..0]&c0.
    // Expanded as independent product terms so no carry ripples between bits.
    function automatic logic la_carry(input logic [MAX_SIZE-1:0] g,
                                      input logic [MAX_SIZE-1:0] p,
                                      input int                  n,
                                      input logic                c0);
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b1;
        for (int j = MAX_SIZE - 1; j >= 0; j--) begin
            if (j < n) begin
                acc = acc | (pp & g[j]);
                pp  = pp & p[j];
            end
        end
        return acc | (pp & c0);
    endfunction

endpackage

// File: rtl/cla_adder_if.sv
// Operand/result bundle for the CLA adder; master drives a/b/cin, slave returns s/cout.
// No handshake: every cycle carries a new operand set.
interface cla_adder_if
    import cla_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] s;
    logic             cout;

    modport master (output a, output b, output cin, input s, input cout);
    modport slave  (input a, input b, input cin, output s, output cout);
endinterface

// File: rtl/cla_group.sv
// SIZE-bit lookahead unit: sum bits plus group generate/propagate, fully combinational.
// Zero latency, no flow control.
module cla_group
    import cla_adder_pkg::*;
#(
    parameter int unsigned SIZE = DEF_SIZE
) (
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    input  logic            c_in,
    output logic [SIZE-1:0] sum,
    output logic            grp_g,
    output logic            grp_p
);

    logic [SIZE-1:0]     g;
    logic [SIZE-1:0]     p;
    logic [SIZE-1:0]     c;
    logic [MAX_SIZE-1:0] g_ext;
    logic [MAX_SIZE-1:0] p_ext;

    always_comb begin
        g     = a & b;
        p     = a ^ b;
        g_ext = MAX_SIZE'(g);
        p_ext = MAX_SIZE'(p);
        c     = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            c[i] = la_carry(g_ext, p_ext, i, c_in);
        end
        sum   = p ^ c;
        // Group generate is the carry out of the group with a zero carry-in.
        grp_g = la_carry(g_ext, p_ext, int'(SIZE), 1'b0);
        grp_p = &p;
    end

endmodule

// File: rtl/cla_adder.sv
// Two-level carry-lookahead adder {cout,s} = a + b + cin, result registered once.
// Latency 1 cycle, one operand set per cycle, never stalls.
module cla_adder
    import cla_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SIZE  = DEF_SIZE
) (
    input  logic          clk,
    input  logic          rst_n,
    cla_adder_if.slave    bus
);

    localparam int unsigned NGRP = WIDTH / SIZE;

    if ((WIDTH == 0) || (WIDTH % SIZE != 0)) begin : g_bad_width
        $error("cla_adder: WIDTH must be a positive multiple of SIZE");
    end
    if ((SIZE < 2) || (SIZE > MAX_SIZE)) begin : g_bad_size
        $error("cla_adder: SIZE must be in 2..8");
    end

    logic [NGRP-1:0]  gg;
    logic [NGRP-1:0]  gp;
    logic [NGRP:0]    gc;
    logic [WIDTH-1:0] sum_c;

    for (genvar k = 0; k < NGRP; k++) begin : g_grp
        cla_group #(.SIZE(SIZE)) u_grp (
            .a     (bus.a[k*SIZE +: SIZE]),
            .b     (bus.b[k*SIZE +: SIZE]),
            .c_in  (gc[k]),
            .sum   (sum_c[k*SIZE +: SIZE]),
            .grp_g (gg[k]),
            .grp_p (gp[k])
        );
    end

    // Second lookahead level: each group carry is its own flat product-term OR
    // over all lower groups and cin, so no carry ripples group to group.
    always_comb begin
        logic acc;
        logic pp;
        gc    = '0;
        gc[0] = bus.cin;
        for (int k = 0; k < int'(NGRP); k++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc = acc | (pp & gg[j]);
                pp  = pp & gp[j];
            end
            gc[k+1] = acc | (pp & bus.cin);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.s    <= '0;
            bus.cout <= 1'b0;
        end else begin
            bus.s    <= sum_c;
            bus.cout <= gc[NGRP];
        end
    end

endmodule

// File: tb/tb_cla_adder.sv
// Self-checking bench for cla_adder at 32/4 and 16/8 with an arithmetic reference model.
module tb_cla_adder;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    cla_adder_if #(.WIDTH(32)) if32 ();
    cla_adder_if #(.WIDTH(16)) if16 ();

    cla_adder #(.WIDTH(32), .SIZE(4)) u_dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if32.slave)
    );

    cla_adder #(.WIDTH(16), .SIZE(8)) u_dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if16.slave)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_tot  = 0;
    bit chk_en = 1'b0;

    // Reference: plain wide addition of whatever was present at the last rising edge.
    logic [32:0] m32;
    logic [16:0] m16;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m32 <= '0;
            m16 <= '0;
        end else begin
            m32 <= {1'b0, if32.a} + {1'b0, if32.b} + 33'(if32.cin);
            m16 <= {1'b0, if16.a} + {1'b0, if16.b} + 17'(if16.cin);
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model32", 64'({if32.cout, if32.s}), 64'(m32));
            check("model16", 64'({if16.cout, if16.s}), 64'(m16));
        end
    end

    task automatic drive(input logic [31:0] a32, input logic [31:0] b32, input logic c32,
                         input logic [15:0] a16, input logic [15:0] b16, input logic c16);
        if32.a = a32; if32.b = b32; if32.cin = c32;
        if16.a = a16; if16.b = b16; if16.cin = c16;
    endtask

    task automatic vec(input logic [31:0] a32, input logic [31:0] b32, input logic c32,
                       input logic [15:0] a16, input logic [15:0] b16, input logic c16);
        @(negedge clk);
        drive(a32, b32, c32, a16, b16, c16);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [31:0] s32, input logic co32,
                       input logic [15:0] s16, input logic co16);
        check({nm, "_s32"},    64'(if32.s),    64'(s32));
        check({nm, "_cout32"}, 64'(if32.cout), 64'(co32));
        check({nm, "_s16"},    64'(if16.s),    64'(s16));
        check({nm, "_cout16"}, 64'(if16.cout), 64'(co16));
    endtask

    initial begin
        drive(32'h1234_5678, 32'h1, 1'b0, 16'h5678, 16'h1, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        lit("rst_noclk", 32'h0, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        lit("rst_held", 32'h0, 1'b0, 16'h0, 1'b0);

        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        vec(32'hFFFF_FFFF, 32'h0, 1'b1, 16'hFFFF, 16'h0, 1'b1);
        lit("fullchain", 32'h0, 1'b1, 16'h0, 1'b1);
        vec(32'h0000_000F, 32'h1, 1'b0, 16'h00FF, 16'h1, 1'b0);
        lit("grpbound", 32'h0000_0010, 1'b0, 16'h0100, 1'b0);
        vec(32'h8000_0000, 32'h8000_0000, 1'b0, 16'h8000, 16'h8000, 1'b0);
        lit("msbcarry", 32'h0, 1'b1, 16'h0, 1'b1);
        vec(32'h0, 32'h0, 1'b1, 16'h0, 16'h0, 1'b1);
        lit("cinonly", 32'h1, 1'b0, 16'h1, 1'b0);
        vec(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 16'h0FFF, 16'hF001, 1'b1);
        lit("midcarry", 32'h8000_0000, 1'b0, 16'h0001, 1'b1);

        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            drive($urandom, $urandom, 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end

        // Reset dropped between edges while random data is still applied.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        lit("midrst", 32'h0, 1'b0, 16'h0, 1'b0);
        @(posedge clk);
        #1;
        lit("midrst_held", 32'h0, 1'b0, 16'h0, 1'b0);
        @(negedge clk);
        drive(32'h5, 32'h7, 1'b1, 16'h5, 16'h7, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        lit("resume", 32'hD, 1'b0, 16'hD, 1'b0);

        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            drive($urandom, $urandom, 1'($urandom_range(0, 1)),
                  16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
